spi_target: RTL and testbench
=============================

Name: spi_target

Overview:
SPI mode-0 target (peripheral) end of the byte-oriented SPI link: the counterpart of the existing SPI host.
- Samples the host's SCLK, MOSI and SCE on the system clock; both directions are MSB first.
- Presents received bytes and accepts transmit bytes through the same Req/Ack and Adv/Ack handshake style the host controller uses.
- Used as the card-side model in SD-card bring-up and as an FPGA-to-FPGA command port.

Parameters:
SYNC_STAGES, 2, number of flops in each input synchronizer (minimum 2).
IDLE_BYTE, 8'hFF, byte shifted out when no transmit data is pending.

Ports:
Clk  input  1  system clock (50 MHz nominal; must be at least 8x SCLK).
Reset  input  1  synchronous, active-high reset.
SCLK  input  1  SPI clock from host; idle low.
MOSI  input  1  serial data from host.
SCE  input  1  chip enable from host, active low.
MISO  output  1  serial data to host.
MisoOe  output  1  MISO drive enable; high while synchronized SCE is low.
TxData  input  8  byte to send next.
TxReq  input  1  level; TxData is valid and pending.
TxAck  output  1  one-cycle pulse when TxData has been loaded into the shifter.
RxData  output  8  last received byte.
RxAdv  output  1  RxData valid; held until RxAck.
RxAck  input  1  controller has consumed RxData.
Overrun  output  1  one-cycle pulse when a byte arrives while RxAdv=1 and RxAck=0.
Busy  output  1  high while a frame is active (synchronized SCE low).
OverrunCount  output  8  saturating overrun count (see Optional Feature).

Behaviour:
- Reset values: MISO=1, MisoOe=0, TxAck=0, RxData=8'h00, RxAdv=0, Overrun=0, Busy=0, OverrunCount=0.
- Reset also clears the bit counter and both shifters and enters WAIT_IDLE.
- Input capture: SCLK, MOSI and SCE each pass through a SYNC_STAGES synchronizer. Edges are detected on the synchronized SCLK and SCE; the synchronized MOSI is sampled on the same cycle as the rising SCLK edge.
- State WAIT_IDLE: go to IDLE once synchronized SCE=1. This guarantees a reset mid-frame never decodes a partial frame.
- State IDLE: MISO=1, MisoOe=0. On the SCE falling edge:
  - load TxData if TxReq=1 and pulse TxAck; otherwise load IDLE_BYTE;
  - drive MISO=bit7 of the loaded byte; BitCnt=0; MisoOe=1; Busy=1; go to ACTIVE.
- State ACTIVE, SCLK rising edge:
  - RxShift={RxShift[6:0],MOSI}; BitCnt++.
  - If BitCnt was 7: RxData={RxShift[6:0],MOSI}, RxAdv=1, BitCnt=0, ByteDone=1.
- State ACTIVE, SCLK falling edge:
  - If ByteDone: load the next byte (TxData with a TxAck pulse if TxReq=1, else IDLE_BYTE), MISO=bit7, clear ByteDone.
  - Otherwise MISO=next bit of TxShift.
- Frame shape: SCE stays low across consecutive bytes; byte boundaries come only from BitCnt.
- MISO latency: at most SYNC_STAGES+1 Clk cycles after the SCLK falling edge.
- SCE rising edge in ACTIVE (mid-byte or not):
  - go to IDLE; the partial byte is discarded and RxAdv is unchanged;
  - BitCnt=0, MISO=1, MisoOe=0, Busy=0;
  - a pending TxReq that was not yet acked stays pending.
- RxAck clears RxAdv on the next Clk edge.
- RxAck in the same cycle a new byte completes: the new byte wins; RxAdv stays 1 and no Overrun is raised.
- Byte completes while RxAdv=1 and RxAck=0: RxData is overwritten and Overrun pulses for one cycle.
- TxData is sampled only in the load cycle. The controller holds TxData while TxReq=1 and drops TxReq after TxAck. If TxReq is still high on the following load, that byte is sent again.

Optional Feature:
Macro SPI_TGT_OVERRUN_CNT_EN.
- Defined: OverrunCount increments on every Overrun pulse, saturates at 8'hFF, and is cleared only by Reset.
- Not defined: OverrunCount is tied to 8'h00, with no counter logic; Overrun pulse behaviour is unchanged.

Test Plan:
1. Host at 5 MHz sends 8'hA5 with TxReq=1, TxData=8'h3C → RxData=8'hA5 with RxAdv=1; host receives 8'h3C; exactly one TxAck pulse.
2. Three back-to-back bytes 8'h01, 8'h02, 8'h03 with SCE held low, TxReq=0 → three RxAdv events (acked between bytes) with those values in order; host receives 8'hFF,8'hFF,8'hFF.
3. Two bytes 8'h11, 8'h22 with no RxAck → RxData=8'h22, one Overrun pulse; with the macro defined OverrunCount=1; after 300 overruns OverrunCount=8'hFF.
4. SCE raised after 4 bits of 8'hF0 → no RxAdv; MISO=1, MisoOe=0; the next full byte 8'h5A is received correctly.
5. Reset asserted mid-byte with SCE still low, then the frame continues → no RxAdv until SCE goes high; the next frame is received correctly.
6. RxAck asserted in the exact cycle the second byte 8'h77 completes → RxAdv=1, RxData=8'h77, Overrun=0; host at 400 kHz gives identical results.

Source files
------------

// File: rtl/spi_target_if.sv
// Bundle of SPI pins and controller-side byte handshakes for spi_target.
interface spi_target_if;
  // Handshakes: TxReq is a level that holds TxData until the one-cycle TxAck
  // pulse marks the load into the shifter; RxAdv holds RxData valid until the
  // controller raises RxAck, which clears RxAdv on the next clock edge.
  logic       SCLK;
  logic       MOSI;
  logic       SCE;
  logic       MISO;
  logic       MisoOe;
  logic [7:0] TxData;
  logic       TxReq;
  logic       TxAck;
  logic [7:0] RxData;
  logic       RxAdv;
  logic       RxAck;
  logic       Overrun;
  logic       Busy;
  logic [7:0] OverrunCount;

  modport slave (
    input  SCLK, MOSI, SCE, TxData, TxReq, RxAck,
    output MISO, MisoOe, TxAck, RxData, RxAdv, Overrun, Busy, OverrunCount
  );

  modport master (
    output SCLK, MOSI, SCE, TxData, TxReq, RxAck,
    input  MISO, MisoOe, TxAck, RxData, RxAdv, Overrun, Busy, OverrunCount
  );
endinterface

// File: rtl/spi_target.sv
// SPI mode-0 target: oversampled SCLK/MOSI/SCE, MSB-first byte shifting both ways.
// Define SPI_TGT_OVERRUN_CNT_EN to build the saturating OverrunCount register.
module spi_target #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
  input  logic           Clk,
  input  logic           Reset,
  spi_target_if.slave    bus,
  output logic [1:0]     dbg_state_o
);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, sce_sync_q;
  logic                   sclk_prev_q, sce_prev_q;
  logic [2:0]             bit_cnt_q;
  logic [6:0]             rx_shift_q;
  logic [6:0]             tx_shift_q;
  logic                   byte_done_q;
  logic                   miso_q, miso_oe_q, busy_q;
  logic                   tx_ack_q, overrun_q, rx_adv_q;
  logic [7:0]             rx_data_q;

  logic sclk_s, mosi_s, sce_s;
  logic sclk_rise, sclk_fall, sce_fall, sce_rise;
  logic [7:0] tx_load_d;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sce_s     = sce_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign sce_fall  = ~sce_s & sce_prev_q;
  assign sce_rise  = sce_s & ~sce_prev_q;
  assign tx_load_d = bus.TxReq ? bus.TxData : IDLE_BYTE;

  // SCE synchronizer resets to "selected" so WAIT_IDLE cannot leave before a
  // genuine high SCE has propagated through the flops.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      sce_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      sce_prev_q  <= 1'b0;
      state_q     <= WAIT_IDLE;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 7'd0;
      tx_shift_q  <= 7'd0;
      byte_done_q <= 1'b0;
      miso_q      <= 1'b1;
      miso_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
      tx_ack_q    <= 1'b0;
      overrun_q   <= 1'b0;
      rx_adv_q    <= 1'b0;
      rx_data_q   <= 8'h00;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.SCLK};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.MOSI};
      sce_sync_q  <= {sce_sync_q[SYNC_STAGES-2:0], bus.SCE};
      sclk_prev_q <= sclk_s;
      sce_prev_q  <= sce_s;
      tx_ack_q    <= 1'b0;
      overrun_q   <= 1'b0;
      if (bus.RxAck) rx_adv_q <= 1'b0;

      case (state_q)
        WAIT_IDLE: begin
          if (sce_s) state_q <= IDLE;
        end
        IDLE: begin
          miso_q    <= 1'b1;
          miso_oe_q <= 1'b0;
          busy_q    <= 1'b0;
          if (sce_fall) begin
            tx_shift_q  <= tx_load_d[6:0];
            miso_q      <= tx_load_d[7];
            tx_ack_q    <= bus.TxReq;
            bit_cnt_q   <= 3'd0;
            byte_done_q <= 1'b0;
            miso_oe_q   <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (sce_rise) begin
            bit_cnt_q   <= 3'd0;
            byte_done_q <= 1'b0;
            miso_q      <= 1'b1;
            miso_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end else if (sclk_rise) begin
            rx_shift_q <= {rx_shift_q[5:0], mosi_s};
            if (bit_cnt_q == 3'd7) begin
              // A completing byte overrides a same-cycle RxAck.
              rx_data_q   <= {rx_shift_q, mosi_s};
              rx_adv_q    <= 1'b1;
              overrun_q   <= rx_adv_q & ~bus.RxAck;
              bit_cnt_q   <= 3'd0;
              byte_done_q <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end else if (sclk_fall) begin
            if (byte_done_q) begin
              tx_shift_q  <= tx_load_d[6:0];
              miso_q      <= tx_load_d[7];
              tx_ack_q    <= bus.TxReq;
              byte_done_q <= 1'b0;
            end else begin
              miso_q     <= tx_shift_q[6];
              tx_shift_q <= {tx_shift_q[5:0], 1'b0};
            end
          end
        end
        default: state_q <= WAIT_IDLE;
      endcase
    end
  end

`ifdef SPI_TGT_OVERRUN_CNT_EN
  logic [7:0] ovr_cnt_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ovr_cnt_q <= 8'h00;
    end else if (overrun_q && ovr_cnt_q != 8'hFF) begin
      ovr_cnt_q <= ovr_cnt_q + 8'd1;
    end
  end

  assign bus.OverrunCount = ovr_cnt_q;
`else
  assign bus.OverrunCount = 8'h00;
`endif

  assign bus.MISO    = miso_q;
  assign bus.MisoOe  = miso_oe_q;
  assign bus.TxAck   = tx_ack_q;
  assign bus.RxData  = rx_data_q;
  assign bus.RxAdv   = rx_adv_q;
  assign bus.Overrun = overrun_q;
  assign bus.Busy    = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: a cycle-stepped SPI host plus a Req/Ack controller model.
`timescale 1ns/1ps
module tb_spi_target;
  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  spi_target_if bus();
  logic [1:0] dbg_state;

  spi_target #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
    .Clk        (clk),
    .Reset      (rst),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int tx_arm_total = 0;
  int tx_ack_total = 0;
  int rx_evt_total = 0;
  int ovr_total = 0;
  logic force_ack = 1'b0;
  logic auto_ack_en = 1'b0;
  logic auto_ack_q = 1'b0;
  logic rx_adv_prev = 1'b0;
  logic [7:0] exp_q[$];

`ifdef SPI_TGT_OVERRUN_CNT_EN
  localparam logic [7:0] EXP_CNT_ONE = 8'h01;
  localparam logic [7:0] EXP_CNT_SAT = 8'hFF;
`else
  localparam logic [7:0] EXP_CNT_ONE = 8'h00;
  localparam logic [7:0] EXP_CNT_SAT = 8'h00;
`endif

  // Controller model: TxReq stays up until its TxAck, RxAck is combinational.
  assign bus.TxReq = (tx_arm_total != tx_ack_total);
  assign bus.RxAck = force_ack | auto_ack_q;

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.TxAck) tx_ack_total++;
    if (bus.Overrun) ovr_total++;
    if (bus.RxAdv && !rx_adv_prev) rx_evt_total++;
    rx_adv_prev = bus.RxAdv;
    if (auto_ack_en && bus.RxAdv && !auto_ack_q) begin
      if (exp_q.size() == 0) begin
        checki("rx_unexpected", 1, 0);
      end else begin
        check8("rx_scoreboard", bus.RxData, exp_q.pop_front());
      end
      auto_ack_q = 1'b1;
    end else begin
      auto_ack_q = 1'b0;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shifts bits hi..lo of mo; half is the SCLK half period in Clk cycles.
  task automatic xfer(input logic [7:0] mo, input int hi, input int lo, input int half,
                      input bit ack_last, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = hi; i >= lo; i--) begin
      bus.MOSI = mo[i];
      wait_clk(half);
      bus.SCLK = 1'b1;
      mi[i] = bus.MISO;
      if (ack_last && i == lo) begin
        // The byte completes on the third posedge after this SCLK rise.
        wait_clk(2);
        force_ack = 1'b1;
        wait_clk(1);
        force_ack = 1'b0;
        wait_clk(half - 3);
      end else begin
        wait_clk(half);
      end
      bus.SCLK = 1'b0;
    end
  endtask

  task automatic frame_begin(input int half);
    bus.SCE = 1'b0;
    wait_clk(half);
  endtask

  task automatic frame_end(input int half);
    wait_clk(half);
    bus.SCE = 1'b1;
    wait_clk(8);
  endtask

  task automatic pulse_ack();
    force_ack = 1'b1;
    wait_clk(1);
    force_ack = 1'b0;
    wait_clk(1);
  endtask

  initial begin
    logic [7:0] mi;
    int evt0, ovr0;
    int halves[2];
    halves[0] = 5;
    halves[1] = 62;

    rst = 1'b1;
    bus.SCLK = 1'b0;
    bus.MOSI = 1'b0;
    bus.SCE = 1'b1;
    bus.TxData = 8'h00;
    wait_clk(3);
    check1("rst_miso", bus.MISO, 1'b1);
    check1("rst_misooe", bus.MisoOe, 1'b0);
    check1("rst_txack", bus.TxAck, 1'b0);
    check8("rst_rxdata", bus.RxData, 8'h00);
    check1("rst_rxadv", bus.RxAdv, 1'b0);
    check1("rst_overrun", bus.Overrun, 1'b0);
    check1("rst_busy", bus.Busy, 1'b0);
    check8("rst_ovrcnt", bus.OverrunCount, 8'h00);
    rst = 1'b0;
    wait_clk(5);
    check8("idle_state", {6'd0, dbg_state}, 8'd1);

    // 1: single byte with pending transmit data
    bus.TxData = 8'h3C;
    tx_arm_total++;
    frame_begin(5);
    check1("t1_misooe", bus.MisoOe, 1'b1);
    check1("t1_busy", bus.Busy, 1'b1);
    xfer(8'hA5, 7, 0, 5, 1'b0, mi);
    check8("t1_host_rx", mi, 8'h3C);
    check8("t1_rxdata", bus.RxData, 8'hA5);
    check1("t1_rxadv", bus.RxAdv, 1'b1);
    frame_end(5);
    checki("t1_txack_count", tx_ack_total, 1);
    check1("t1_busy_end", bus.Busy, 1'b0);
    pulse_ack();
    check1("t1_rxadv_cleared", bus.RxAdv, 1'b0);

    // 2: three back-to-back bytes, no transmit data, acked between bytes
    evt0 = rx_evt_total;
    auto_ack_en = 1'b1;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h03);
    frame_begin(5);
    xfer(8'h01, 7, 0, 5, 1'b0, mi);
    check8("t2_host_rx0", mi, 8'hFF);
    xfer(8'h02, 7, 0, 5, 1'b0, mi);
    check8("t2_host_rx1", mi, 8'hFF);
    xfer(8'h03, 7, 0, 5, 1'b0, mi);
    check8("t2_host_rx2", mi, 8'hFF);
    frame_end(5);
    auto_ack_en = 1'b0;
    checki("t2_exp_q_empty", exp_q.size(), 0);
    checki("t2_rx_events", rx_evt_total - evt0, 3);
    checki("t2_txack_count", tx_ack_total, 1);

    // 3: overrun, then saturation of the overrun counter
    ovr0 = ovr_total;
    frame_begin(5);
    xfer(8'h11, 7, 0, 5, 1'b0, mi);
    xfer(8'h22, 7, 0, 5, 1'b0, mi);
    frame_end(5);
    check8("t3_rxdata", bus.RxData, 8'h22);
    checki("t3_overruns", ovr_total - ovr0, 1);
    check8("t3_ovrcnt_one", bus.OverrunCount, EXP_CNT_ONE);
    frame_begin(4);
    for (int n = 0; n < 300; n++) xfer(8'hC6, 7, 0, 4, 1'b0, mi);
    frame_end(4);
    checki("t3_overruns_301", ovr_total - ovr0, 301);
    check8("t3_ovrcnt_sat", bus.OverrunCount, EXP_CNT_SAT);
    check8("t3_rxdata_last", bus.RxData, 8'hC6);
    pulse_ack();

    // 4: frame aborted after four bits, then a clean byte
    evt0 = rx_evt_total;
    frame_begin(5);
    xfer(8'hF0, 7, 4, 5, 1'b0, mi);
    frame_end(5);
    check1("t4_rxadv", bus.RxAdv, 1'b0);
    check1("t4_miso", bus.MISO, 1'b1);
    check1("t4_misooe", bus.MisoOe, 1'b0);
    check1("t4_busy", bus.Busy, 1'b0);
    checki("t4_no_event", rx_evt_total - evt0, 0);
    frame_begin(5);
    xfer(8'h5A, 7, 0, 5, 1'b0, mi);
    frame_end(5);
    check8("t4_rxdata", bus.RxData, 8'h5A);
    check1("t4_rxadv_after", bus.RxAdv, 1'b1);
    pulse_ack();

    // 5: reset mid-byte while SCE stays low
    evt0 = rx_evt_total;
    frame_begin(5);
    xfer(8'hC3, 7, 4, 5, 1'b0, mi);
    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(1);
    check8("t5_wait_idle", {6'd0, dbg_state}, 8'd0);
    check1("t5_busy", bus.Busy, 1'b0);
    check1("t5_misooe", bus.MisoOe, 1'b0);
    check1("t5_miso", bus.MISO, 1'b1);
    xfer(8'hC3, 3, 0, 5, 1'b0, mi);
    xfer(8'h99, 7, 0, 5, 1'b0, mi);
    check1("t5_rxadv", bus.RxAdv, 1'b0);
    checki("t5_no_event", rx_evt_total - evt0, 0);
    check8("t5_rxdata_reset", bus.RxData, 8'h00);
    frame_end(5);
    check8("t5_idle", {6'd0, dbg_state}, 8'd1);
    frame_begin(5);
    xfer(8'h3E, 7, 0, 5, 1'b0, mi);
    frame_end(5);
    check8("t5_rxdata", bus.RxData, 8'h3E);
    check1("t5_rxadv_after", bus.RxAdv, 1'b1);
    pulse_ack();

    // 6: RxAck coincides with completion of the second byte (fast and ~400 kHz host)
    for (int k = 0; k < 2; k++) begin
      ovr0 = ovr_total;
      frame_begin(halves[k]);
      xfer(8'h10, 7, 0, halves[k], 1'b0, mi);
      check8("t6_rxdata_first", bus.RxData, 8'h10);
      xfer(8'h77, 7, 0, halves[k], 1'b1, mi);
      check8("t6_host_rx", mi, 8'hFF);
      check1("t6_rxadv", bus.RxAdv, 1'b1);
      check8("t6_rxdata", bus.RxData, 8'h77);
      checki("t6_no_overrun", ovr_total - ovr0, 0);
      frame_end(halves[k]);
      pulse_ack();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
